irq_ctrl: RTL and testbench
===========================

# irq_ctrl

Interrupt controller sitting in front of the CP0 block of the pipelined CPU. It collects N external interrupt lines, synchronises them and latches rising edges as pending. It masks and prioritises the pending sources, then drives CP0's single interrupt request. It sequences request, acceptance and ERET return, so only one source is in service at a time, and exposes MASK/PEND/CAUSE/ENABLE registers on a small word-addressed bus for the CPU's load/store path.

## Interface
Parameters:
- N_SRC, 8, number of interrupt sources (1..32)

Ports:
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- src_in  in  N_SRC  raw external interrupt lines, asynchronous, level
- reg_we  in  1  register write strobe
- reg_addr  in  2  register select: 0 MASK, 1 PEND, 2 CAUSE, 3 ENABLE
- reg_wdata  in  32  write data
- reg_rdata  out  32  read data, combinational from reg_addr
- irq_out  out  1  interrupt request to CP0 (drives its ir_in)
- irq_taken  in  1  one-cycle pulse: CP0 has taken the interrupt (jump_en with no ERET)
- eret  in  1  one-cycle pulse: CP0 executed ERET
- irq_id  out  5  index of the source being requested or serviced
- busy  out  1  high in REQ or SERVICE

## Operation
- Sync: each src_in bit passes through 2 flops (s1, s2) plus a history flop s3. Rising edge = s2 & ~s3.
- PEND[i] set on edge i. Cleared by a write to PEND with bit i = 1 (W1C), or by the transition REQ->SERVICE for i = irq_id. A set in the same cycle as a clear: set wins.
- MASK: R/W, reset 0 (all masked). ENABLE: bit0 = global enable, R/W, reset 0, other bits read 0.
- CAUSE (read-only): bit31 = busy, bits[4:0] = irq_id, others 0. Writes are ignored.
- Bits at or above N_SRC read 0 in MASK and PEND. Writes to those bits are ignored.
- cand = PEND & MASK & {N_SRC{ENABLE[0]}}. Winner = lowest set index (fixed priority, index 0 highest).
- FSM (2-bit state):
  - IDLE: if cand != 0, latch irq_id = winner and go to REQ. Otherwise stay.
  - REQ: irq_out = 1.
    - If irq_taken: clear PEND[irq_id] and go to SERVICE.
    - Else if cand[irq_id] = 0 (masked, disabled or W1C'd meanwhile): withdraw to IDLE.
    - Else stay. irq_id is not re-arbitrated while in REQ, even if a higher-priority source arrives.
  - SERVICE: irq_out = 0. If eret, go to IDLE. Other edges still set PEND. irq_taken is ignored.
- eret in IDLE or REQ is ignored.
- irq_taken in IDLE is ignored. irq_taken in REQ takes precedence over the withdraw condition in the same cycle.

## Timing
- Reset values: irq_out 0, busy 0, irq_id 0, reg_rdata reflects reset registers (all 0). State IDLE, s1/s2/s3 = 0.
- src_in rises before edge k: PEND bit visible after edge k+2. If enabled, masked-in and idle, irq_out is high after edge k+3.
- irq_out is registered: high after the edge entering REQ, low after the edge leaving REQ.
- After eret at edge e, the next pending source can raise irq_out after edge e+1. Back-to-back service costs 1 IDLE cycle.
- Register writes take effect at the clock edge and are visible to arbitration in the next cycle.
- A write to MASK or ENABLE that removes irq_id drops irq_out one cycle after the write edge (withdraw).
- Reset mid-operation returns to IDLE and clears all registers in the same edge.

## Test plan
- Single source: ENABLE=1, MASK=0x04, pulse src_in[2] -> irq_out high 3 edges later, irq_id=2, CAUSE=0x80000002. irq_taken -> PEND=0, busy=1, irq_out=0. eret -> busy=0.
- Priority: MASK=0xFF, raise src 5 and 3 in the same cycle -> irq_id=3 first. After taken+eret, irq_id=5 after 1 IDLE cycle.
- Masked/disabled: MASK=0, edge on src 1 -> PEND=0x02, irq_out stays 0. Set MASK=0x02 -> irq_out high. Write ENABLE=0 while in REQ -> withdraw, irq_out 0, PEND still 0x02.
- Nesting block: in SERVICE for id 4, edge on src 0 -> PEND=0x01, irq_out stays 0 until eret, then irq_id=0.
- W1C race: write PEND=0x01 in the same cycle an edge sets bit 0 -> PEND bit 0 stays 1. Writing 0x01 on a later cycle clears it.
- Reset in SERVICE: rst=1 for 1 cycle -> irq_out 0, busy 0, MASK/PEND/ENABLE 0. A subsequent eret is ignored.

Source files
------------

// File: rtl/irq_ctrl.sv
// -----------------------------------------------------------------------------
// irq_ctrl
//
// Interrupt controller in front of CP0. Collects N_SRC asynchronous interrupt
// lines, synchronises them, latches rising edges as pending, then masks and
// prioritises them (lowest index wins). It drives CP0's single interrupt
// request and sequences request, acceptance and ERET return, so only one
// source is in service at a time.
//
// Ports:
//   clk        clock
//   rst        synchronous, active-high reset
//   src_in     raw external interrupt lines (asynchronous, level)
//   reg_we     register write strobe
//   reg_addr   register select: 0 MASK, 1 PEND, 2 CAUSE, 3 ENABLE
//   reg_wdata  write data
//   reg_rdata  read data, combinational from reg_addr
//   irq_out    interrupt request to CP0
//   irq_taken  one-cycle pulse: CP0 took the interrupt
//   eret       one-cycle pulse: CP0 executed ERET
//   irq_id     index of the source being requested or serviced
//   busy       high while a request is outstanding or in service
// -----------------------------------------------------------------------------
module irq_ctrl #(
  parameter int N_SRC = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N_SRC-1:0] src_in,
  input  logic             reg_we,
  input  logic [1:0]       reg_addr,
  input  logic [31:0]      reg_wdata,
  output logic [31:0]      reg_rdata,
  output logic             irq_out,
  input  logic             irq_taken,
  input  logic             eret,
  output logic [4:0]       irq_id,
  output logic             busy
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    REQ     = 2'd1,
    SERVICE = 2'd2
  } state_t;

  localparam logic [1:0] ADDR_MASK   = 2'd0;
  localparam logic [1:0] ADDR_PEND   = 2'd1;
  localparam logic [1:0] ADDR_CAUSE  = 2'd2;
  localparam logic [1:0] ADDR_ENABLE = 2'd3;

  state_t state_reg, state_next;

  logic [N_SRC-1:0] s1_reg, s2_reg, s3_reg;
  logic [N_SRC-1:0] rise;
  logic [N_SRC-1:0] mask_reg, mask_next;
  logic [N_SRC-1:0] pend_reg, pend_next;
  logic [N_SRC-1:0] w1c_clr;
  logic [N_SRC-1:0] take_clr;
  logic [N_SRC-1:0] cand;
  logic [31:0]      cand_ext;
  logic             cand_any;
  logic             enable_reg, enable_next;
  logic [4:0]       id_reg, id_next;
  logic [4:0]       winner;
  logic             take;

  logic mask_we, pend_we, enable_we;

  assign mask_we   = reg_we && (reg_addr == ADDR_MASK);
  assign pend_we   = reg_we && (reg_addr == ADDR_PEND);
  assign enable_we = reg_we && (reg_addr == ADDR_ENABLE);

  // ---------------------------------------------------------------------------
  // Per-line synchroniser (s1, s2) plus history flop s3 for edge detection,
  // and the per-line clear terms for PEND.
  // ---------------------------------------------------------------------------
  genvar gi;
  generate
    for (gi = 0; gi < N_SRC; gi++) begin : g_line
      always_ff @(posedge clk) begin
        if (rst) begin
          s1_reg[gi] <= 1'b0;
          s2_reg[gi] <= 1'b0;
          s3_reg[gi] <= 1'b0;
        end else begin
          s1_reg[gi] <= src_in[gi];
          s2_reg[gi] <= s1_reg[gi];
          s3_reg[gi] <= s2_reg[gi];
        end
      end

      assign rise[gi]     = s2_reg[gi] & ~s3_reg[gi];
      assign w1c_clr[gi]  = pend_we & reg_wdata[gi];
      // Acceptance of the requested source retires its pending bit.
      assign take_clr[gi] = take && (id_reg == 5'(gi));
    end
  endgenerate

  // ---------------------------------------------------------------------------
  // Register next-state. A new edge overrides any clear in the same cycle.
  // Bits at or above N_SRC simply do not exist, so writes to them vanish.
  // ---------------------------------------------------------------------------
  always_comb begin
    mask_next   = mask_reg;
    enable_next = enable_reg;
    if (mask_we) begin
      mask_next = reg_wdata[N_SRC-1:0];
    end
    if (enable_we) begin
      enable_next = reg_wdata[0];
    end
    pend_next = (pend_reg & ~(w1c_clr | take_clr)) | rise;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      mask_reg   <= '0;
      pend_reg   <= '0;
      enable_reg <= 1'b0;
    end else begin
      mask_reg   <= mask_next;
      pend_reg   <= pend_next;
      enable_reg <= enable_next;
    end
  end

  // ---------------------------------------------------------------------------
  // Candidate set and fixed-priority arbitration (index 0 highest).
  // ---------------------------------------------------------------------------
  assign cand     = pend_reg & mask_reg & {N_SRC{enable_reg}};
  assign cand_any = |cand;
  // Zero-extended copy so the 5-bit irq_id can index it for any N_SRC.
  assign cand_ext = 32'(cand);

  always_comb begin
    winner = '0;
    // Scan downward so the lowest set index is the last one written.
    for (int i = N_SRC - 1; i >= 0; i--) begin
      if (cand[i]) begin
        winner = 5'(i);
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Request / service sequencer.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= IDLE;
      id_reg    <= '0;
    end else begin
      state_reg <= state_next;
      id_reg    <= id_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    id_next    = id_reg;
    take       = 1'b0;
    case (state_reg)
      IDLE: begin
        if (cand_any) begin
          id_next    = winner;
          state_next = REQ;
        end
      end
      REQ: begin
        // Acceptance beats withdrawal; the latched id is never re-arbitrated.
        if (irq_taken) begin
          take       = 1'b1;
          state_next = SERVICE;
        end else if (!cand_ext[id_reg]) begin
          state_next = IDLE;
        end
      end
      SERVICE: begin
        if (eret) begin
          state_next = IDLE;
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // Both outputs are decoded straight from the state register, so they are
  // glitch-free and change only at clock edges.
  assign irq_out = (state_reg == REQ);
  assign busy    = (state_reg != IDLE);
  assign irq_id  = id_reg;

  // ---------------------------------------------------------------------------
  // Read mux.
  // ---------------------------------------------------------------------------
  always_comb begin
    reg_rdata = '0;
    case (reg_addr)
      ADDR_MASK:   reg_rdata = 32'(mask_reg);
      ADDR_PEND:   reg_rdata = 32'(pend_reg);
      ADDR_CAUSE:  reg_rdata = {busy, 26'd0, id_reg};
      ADDR_ENABLE: reg_rdata = {31'd0, enable_reg};
      default:     reg_rdata = '0;
    endcase
  end

endmodule

// File: tb/tb_irq_ctrl.sv
// -----------------------------------------------------------------------------
// tb_irq_ctrl
//
// Self-checking bench for irq_ctrl (N_SRC = 8). A table of register
// write/readback vectors covers the register map; hand-written sequences cover
// single source, priority, masking/withdraw, nesting block, W1C race and reset
// during service. Expected values go into a scoreboard queue when the check is
// issued and are popped when the DUT output is sampled.
// -----------------------------------------------------------------------------
module tb_irq_ctrl;

  localparam int N = 8;

  logic          clk;
  logic          rst;
  logic [N-1:0]  src_in;
  logic          reg_we;
  logic [1:0]    reg_addr;
  logic [31:0]   reg_wdata;
  logic [31:0]   reg_rdata;
  logic          irq_out;
  logic          irq_taken;
  logic          eret;
  logic [4:0]    irq_id;
  logic          busy;

  irq_ctrl #(.N_SRC(N)) dut (
    .clk       (clk),
    .rst       (rst),
    .src_in    (src_in),
    .reg_we    (reg_we),
    .reg_addr  (reg_addr),
    .reg_wdata (reg_wdata),
    .reg_rdata (reg_rdata),
    .irq_out   (irq_out),
    .irq_taken (irq_taken),
    .eret      (eret),
    .irq_id    (irq_id),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string       name;
    bit          is_stat;
    logic [31:0] exp;
    logic [31:0] care;
  } sb_t;

  typedef struct {
    string       name;
    logic        we;
    logic [1:0]  waddr;
    logic [31:0] wdata;
    logic [1:0]  raddr;
    logic [31:0] exp;
  } vec_t;

  sb_t  sb_q[$];
  vec_t vecs[7];
  int   n_vec  = 0;
  int   n_fail = 0;

  // Advance to just after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Compare the front of the scoreboard with the DUT, 1 ns after setup.
  task automatic compare_front();
    sb_t         item;
    logic [31:0] act;
    #1;
    item = sb_q.pop_front();
    act  = item.is_stat ? {25'd0, irq_out, busy, irq_id} : reg_rdata;
    n_vec++;
    if ((act & item.care) !== (item.exp & item.care)) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h required 0x%08h (care 0x%08h)",
               item.name, act, item.exp, item.care);
    end else begin
      $display("ok   %s: 0x%08h", item.name, act & item.care);
    end
  endtask

  task automatic chk_reg(input string name, input logic [1:0] addr, input logic [31:0] exp);
    reg_addr = addr;
    sb_q.push_back('{name: name, is_stat: 1'b0, exp: exp, care: 32'hFFFF_FFFF});
    compare_front();
  endtask

  // Status word is {irq_out, busy, irq_id[4:0]}; irq_id is optionally ignored.
  task automatic chk_stat(input string name, input logic irq, input logic bsy,
                          input logic [4:0] id, input bit chk_id);
    sb_q.push_back('{name: name, is_stat: 1'b1,
                     exp: {25'd0, irq, bsy, id},
                     care: chk_id ? 32'h0000_007F : 32'h0000_0060});
    compare_front();
  endtask

  task automatic write_reg(input logic [1:0] addr, input logic [31:0] data);
    reg_we    = 1'b1;
    reg_addr  = addr;
    reg_wdata = data;
    tick();
    reg_we    = 1'b0;
    reg_wdata = '0;
  endtask

  // One-cycle high pulse on the selected lines; the rising edge is sampled
  // at the edge inside this task.
  task automatic pulse_src(input logic [N-1:0] m);
    src_in = src_in | m;
    tick();
    src_in = src_in & ~m;
  endtask

  task automatic take_pulse();
    irq_taken = 1'b1;
    tick();
    irq_taken = 1'b0;
  endtask

  task automatic eret_pulse();
    eret = 1'b1;
    tick();
    eret = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, got timeout required finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0] = '{"tbl_mask_all",    1'b1, 2'd0, 32'hFFFF_FFFF, 2'd0, 32'h0000_00FF};
    vecs[1] = '{"tbl_enable_set",  1'b1, 2'd3, 32'hFFFF_FFFF, 2'd3, 32'h0000_0001};
    vecs[2] = '{"tbl_cause_ro",    1'b1, 2'd2, 32'hFFFF_FFFF, 2'd2, 32'h0000_0000};
    vecs[3] = '{"tbl_mask_5a",     1'b1, 2'd0, 32'h0000_005A, 2'd0, 32'h0000_005A};
    vecs[4] = '{"tbl_pend_w1c",    1'b1, 2'd1, 32'hFFFF_FFFF, 2'd1, 32'h0000_0000};
    vecs[5] = '{"tbl_enable_clr",  1'b1, 2'd3, 32'hFFFF_FFFE, 2'd3, 32'h0000_0000};
    vecs[6] = '{"tbl_mask_zero",   1'b1, 2'd0, 32'h0000_0000, 2'd0, 32'h0000_0000};

    rst       = 1'b1;
    src_in    = '0;
    reg_we    = 1'b0;
    reg_addr  = '0;
    reg_wdata = '0;
    irq_taken = 1'b0;
    eret      = 1'b0;
    tick();
    tick();
    rst = 1'b0;

    // Reset state
    chk_stat("rst_stat", 1'b0, 1'b0, 5'd0, 1'b1);
    chk_reg("rst_mask",   2'd0, 32'h0);
    chk_reg("rst_pend",   2'd1, 32'h0);
    chk_reg("rst_cause",  2'd2, 32'h0);
    chk_reg("rst_enable", 2'd3, 32'h0);

    // Register map table
    for (int i = 0; i < 7; i++) begin
      if (vecs[i].we) write_reg(vecs[i].waddr, vecs[i].wdata);
      chk_reg(vecs[i].name, vecs[i].raddr, vecs[i].exp);
    end

    // Single source
    write_reg(2'd3, 32'h1);
    write_reg(2'd0, 32'h04);
    pulse_src(8'h04);
    tick();
    tick();
    chk_reg("t1_pend", 2'd1, 32'h04);
    chk_stat("t1_not_yet", 1'b0, 1'b0, 5'd0, 1'b0);
    tick();
    chk_stat("t1_req", 1'b1, 1'b1, 5'd2, 1'b1);
    chk_reg("t1_cause", 2'd2, 32'h8000_0002);
    take_pulse();
    chk_reg("t1_pend_clr", 2'd1, 32'h0);
    chk_stat("t1_service", 1'b0, 1'b1, 5'd2, 1'b1);
    eret_pulse();
    chk_stat("t1_eret", 1'b0, 1'b0, 5'd0, 1'b0);

    // Priority
    write_reg(2'd0, 32'hFF);
    pulse_src(8'h28);
    tick();
    tick();
    tick();
    chk_stat("t2_first", 1'b1, 1'b1, 5'd3, 1'b1);
    chk_reg("t2_pend", 2'd1, 32'h28);
    take_pulse();
    chk_reg("t2_pend_after_take", 2'd1, 32'h20);
    chk_stat("t2_service", 1'b0, 1'b1, 5'd3, 1'b1);
    eret_pulse();
    chk_stat("t2_idle_gap", 1'b0, 1'b0, 5'd0, 1'b0);
    tick();
    chk_stat("t2_second", 1'b1, 1'b1, 5'd5, 1'b1);
    take_pulse();
    eret_pulse();
    chk_stat("t2_done", 1'b0, 1'b0, 5'd0, 1'b0);
    chk_reg("t2_pend_empty", 2'd1, 32'h0);

    // Masked, then unmasked, then withdrawn by ENABLE=0
    write_reg(2'd0, 32'h0);
    pulse_src(8'h02);
    tick();
    tick();
    chk_reg("t3_pend", 2'd1, 32'h02);
    tick();
    chk_stat("t3_masked", 1'b0, 1'b0, 5'd0, 1'b0);
    write_reg(2'd0, 32'h02);
    chk_stat("t3_unmask_edge", 1'b0, 1'b0, 5'd0, 1'b0);
    tick();
    chk_stat("t3_req", 1'b1, 1'b1, 5'd1, 1'b1);
    write_reg(2'd3, 32'h0);
    chk_stat("t3_disable_edge", 1'b1, 1'b1, 5'd1, 1'b1);
    tick();
    chk_stat("t3_withdrawn", 1'b0, 1'b0, 5'd0, 1'b0);
    chk_reg("t3_pend_kept", 2'd1, 32'h02);
    write_reg(2'd1, 32'h02);
    chk_reg("t3_pend_w1c", 2'd1, 32'h0);
    write_reg(2'd3, 32'h1);

    // Nesting block
    write_reg(2'd0, 32'h11);
    pulse_src(8'h10);
    tick();
    tick();
    tick();
    chk_stat("t4_req4", 1'b1, 1'b1, 5'd4, 1'b1);
    take_pulse();
    pulse_src(8'h01);
    tick();
    tick();
    chk_reg("t4_pend0", 2'd1, 32'h01);
    chk_stat("t4_blocked", 1'b0, 1'b1, 5'd4, 1'b1);
    tick();
    chk_stat("t4_still_blocked", 1'b0, 1'b1, 5'd4, 1'b1);
    eret_pulse();
    chk_stat("t4_idle_gap", 1'b0, 1'b0, 5'd0, 1'b0);
    tick();
    chk_stat("t4_req0", 1'b1, 1'b1, 5'd0, 1'b1);
    take_pulse();
    chk_reg("t4_pend_clr", 2'd1, 32'h0);
    eret_pulse();

    // W1C race: clear and set of bit 0 at the same edge
    write_reg(2'd0, 32'h0);
    pulse_src(8'h01);
    tick();
    write_reg(2'd1, 32'h01);
    chk_reg("t5_set_wins", 2'd1, 32'h01);
    write_reg(2'd1, 32'h01);
    chk_reg("t5_later_clear", 2'd1, 32'h0);

    // Reset during service
    write_reg(2'd0, 32'h04);
    pulse_src(8'h04);
    tick();
    tick();
    tick();
    chk_stat("t6_req", 1'b1, 1'b1, 5'd2, 1'b1);
    take_pulse();
    pulse_src(8'h02);
    tick();
    tick();
    chk_reg("t6_pend", 2'd1, 32'h02);
    chk_stat("t6_service", 1'b0, 1'b1, 5'd2, 1'b1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk_stat("t6_rst_stat", 1'b0, 1'b0, 5'd0, 1'b1);
    chk_reg("t6_rst_mask",   2'd0, 32'h0);
    chk_reg("t6_rst_pend",   2'd1, 32'h0);
    chk_reg("t6_rst_enable", 2'd3, 32'h0);
    chk_reg("t6_rst_cause",  2'd2, 32'h0);
    eret_pulse();
    chk_stat("t6_eret_ignored", 1'b0, 1'b0, 5'd0, 1'b1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
